// File: rtl/pb_adder_sched.sv
// Shares one accumulating adder among NUM_PB push-button requesters.
// Rising button edges latch the operand bus into per-button slots; a round-robin arbiter drains them.
module pb_adder_sched #(
   parameter int NUM_PB = 5,
   parameter int Y_W    = 4,
   parameter int SUM_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_PB-1:0] PB,
   input  logic [Y_W-1:0]    Y,
   output logic [SUM_W-1:0]  sum,
   output logic              carry,
   output logic [NUM_PB-1:0] pending,
   output logic [NUM_PB-1:0] grant,
   output logic              done,
   output logic              drop
);

   localparam int PTR_W = (NUM_PB > 1) ? $clog2(NUM_PB) : 1;

   typedef enum logic {
      IDLE,
      ADD
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [NUM_PB-1:0] pb_q;
   logic [NUM_PB-1:0] rise;
   logic [NUM_PB-1:0] add_clear;
   logic [NUM_PB-1:0] capture;
   logic [NUM_PB-1:0] pending_next;
   logic [NUM_PB-1:0] grant_next;
   logic [Y_W-1:0]    opnd [NUM_PB];

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_next;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  grant_idx_next;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_found;

   logic [SUM_W:0]    add_res;
   logic [SUM_W-1:0]  sum_next;
   logic              carry_next;
   logic              done_next;
   logic              drop_next;

   assign rise = PB & ~pb_q;

   // A slot being drained this cycle is free again, so a press on it recaptures instead of dropping.
   assign add_clear    = (state == ADD) ? grant : '0;
   assign capture      = rise & ~(pending & ~add_clear);
   assign drop_next    = |(rise & pending & ~add_clear);
   assign pending_next = (pending & ~add_clear) | rise;

   assign add_res = {1'b0, sum} + (SUM_W+1)'(opnd[grant_idx]);

   always_comb begin
      int idx;
      idx        = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_PB; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_PB;
         if (!pick_found && pending[idx]) begin
            pick_found = 1'b1;
            pick_idx   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      state_next     = state;
      grant_next     = '0;
      grant_idx_next = grant_idx;
      rr_next        = rr_ptr;
      sum_next       = sum;
      carry_next     = carry;
      done_next      = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_next     = {{(NUM_PB-1){1'b0}}, 1'b1} << pick_idx;
               grant_idx_next = pick_idx;
               state_next     = ADD;
            end
         end
         ADD: begin
            {carry_next, sum_next} = add_res;
            rr_next    = (grant_idx == PTR_W'(NUM_PB-1)) ? '0 : grant_idx + 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pb_q      <= '0;
         pending   <= '0;
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
         sum       <= '0;
         carry     <= 1'b0;
         done      <= 1'b0;
         drop      <= 1'b0;
         for (int i = 0; i < NUM_PB; i++) begin
            opnd[i] <= '0;
         end
      end else begin
         pb_q      <= PB;
         pending   <= pending_next;
         grant     <= grant_next;
         grant_idx <= grant_idx_next;
         rr_ptr    <= rr_next;
         sum       <= sum_next;
         carry     <= carry_next;
         done      <= done_next;
         drop      <= drop_next;
         for (int i = 0; i < NUM_PB; i++) begin
            if (capture[i]) begin
               opnd[i] <= Y;
            end
         end
      end
   end

endmodule

// File: tb/tb_pb_adder_sched.sv
// Directed bench for pb_adder_sched: reset, single add, wraparound, round-robin order,
// drop/collision handling and reset during an add.
module tb_pb_adder_sched;

   logic       clk;
   logic       reset;
   logic [4:0] PB;
   logic [3:0] Y;
   logic [5:0] sum;
   logic       carry;
   logic [4:0] pending;
   logic [4:0] grant;
   logic       done;
   logic       drop;

   int vectors;
   int miscompares;

   pb_adder_sched #(.NUM_PB(5), .Y_W(4), .SUM_W(6)) dut (
      .clk     (clk),
      .reset   (reset),
      .PB      (PB),
      .Y       (Y),
      .sum     (sum),
      .carry   (carry),
      .pending (pending),
      .grant   (grant),
      .done    (done),
      .drop    (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled and inputs changed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      PB    = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      PB    = 5'h1F;
      Y     = 4'hF;
      repeat (3) tick();
      vectors++; if (sum !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_sum: got %0d expected 0", sum); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_carry: got %0b expected 0", carry); end
      vectors++; if (pending !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_pending: got %b expected 00000", pending); end
      vectors++; if (grant !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_grant: got %b expected 00000", grant); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
      vectors++; if (drop !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drop: got %0b expected 0", drop); end
      reset = 1'b0;
      PB    = '0;
      tick();
      tick();
      vectors++; if (pending !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_release_pending: got %b expected 00000", pending); end
      vectors++; if (grant !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_release_grant: got %b expected 00000", grant); end
   endtask

   task automatic test_single_add();
      Y  = 4'd8;
      PB = 5'b00001;
      tick();
      vectors++; if (pending !== 5'b00001) begin miscompares++; $display("[TB] FAIL single_pending: got %b expected 00001", pending); end
      vectors++; if (grant !== 5'b00000) begin miscompares++; $display("[TB] FAIL single_grant_early: got %b expected 00000", grant); end
      PB = '0;
      tick();
      vectors++; if (grant !== 5'b00001) begin miscompares++; $display("[TB] FAIL single_grant: got %b expected 00001", grant); end
      tick();
      vectors++; if (sum !== 6'd8) begin miscompares++; $display("[TB] FAIL single_sum: got %0d expected 8", sum); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL single_carry: got %0b expected 0", carry); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL single_done: got %0b expected 1", done); end
      vectors++; if (pending !== 5'b0) begin miscompares++; $display("[TB] FAIL single_pending_clear: got %b expected 00000", pending); end
      tick();
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL single_done_pulse: got %0b expected 0", done); end
   endtask

   task automatic test_overflow();
      int n;
      int exp_prev;
      int exp_total;
      do_reset();
      Y = 4'd8;
      for (int i = 0; i < 5; i++) begin
         PB = 5'b00001 << i;
         tick();
      end
      PB = '0;
      n  = 0;
      while ((pending !== 5'b0 || grant !== 5'b0) && n < 40) begin
         tick();
         n++;
      end
      vectors++; if (n >= 40) begin miscompares++; $display("[TB] FAIL overflow_drain_timeout: got %0d cycles expected < 40", n); end
      vectors++; if (sum !== 6'd40) begin miscompares++; $display("[TB] FAIL overflow_sum40: got %0d expected 40", sum); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL overflow_carry40: got %0b expected 0", carry); end
      exp_prev = 40;
      for (int k = 0; k < 8; k++) begin
         PB = 5'b00001;
         tick();
         PB = '0;
         n  = 0;
         while (done !== 1'b1 && n < 10) begin
            tick();
            n++;
         end
         exp_total = exp_prev + 8;
         vectors++; if (n >= 10) begin miscompares++; $display("[TB] FAIL overflow_done_timeout[%0d]: got %0d cycles expected < 10", k, n); end
         vectors++; if (sum !== 6'(exp_total % 64)) begin miscompares++; $display("[TB] FAIL overflow_sum[%0d]: got %0d expected %0d", k, sum, exp_total % 64); end
         vectors++; if (carry !== (exp_total >= 64)) begin miscompares++; $display("[TB] FAIL overflow_carry[%0d]: got %0b expected %0b", k, carry, exp_total >= 64); end
         exp_prev = exp_total % 64;
      end
   endtask

   task automatic test_round_robin();
      logic [4:0] seen[$];
      logic [4:0] exp_g [3];
      exp_g = '{5'b00001, 5'b00100, 5'b10000};
      do_reset();
      Y  = 4'd3;
      PB = 5'b10101;
      tick();
      PB = '0;
      for (int c = 0; c < 12; c++) begin
         if (grant !== 5'b0) seen.push_back(grant);
         tick();
      end
      vectors++; if (seen.size() != 3) begin miscompares++; $display("[TB] FAIL rr_grant_count: got %0d expected 3", seen.size()); end
      for (int j = 0; j < 3; j++) begin
         vectors++;
         if (j >= seen.size()) begin
            miscompares++; $display("[TB] FAIL rr_order[%0d]: got none expected %b", j, exp_g[j]);
         end else if (seen[j] !== exp_g[j]) begin
            miscompares++; $display("[TB] FAIL rr_order[%0d]: got %b expected %b", j, seen[j], exp_g[j]);
         end
      end
      vectors++; if (sum !== 6'd9) begin miscompares++; $display("[TB] FAIL rr_sum: got %0d expected 9", sum); end

      // Draining slot 0 moves the pointer to 1, so slot 2 must now beat slot 0.
      Y  = 4'd1;
      PB = 5'b00001;
      tick();
      PB = '0;
      repeat (4) tick();
      seen.delete();
      Y  = 4'd2;
      PB = 5'b00101;
      tick();
      PB = '0;
      for (int c = 0; c < 8; c++) begin
         if (grant !== 5'b0) seen.push_back(grant);
         tick();
      end
      vectors++;
      if (seen.size() < 2 || seen[0] !== 5'b00100 || seen[1] !== 5'b00001) begin
         miscompares++;
         if (seen.size() >= 2) $display("[TB] FAIL rr_pointer_order: got %b,%b expected 00100,00001", seen[0], seen[1]);
         else $display("[TB] FAIL rr_pointer_order: got %0d grants expected 2", seen.size());
      end
      vectors++; if (sum !== 6'd14) begin miscompares++; $display("[TB] FAIL rr_pointer_sum: got %0d expected 14", sum); end
   endtask

   task automatic test_drop_collision();
      do_reset();
      Y  = 4'd5;
      PB = 5'b00011;
      tick();
      PB = '0;
      tick();
      vectors++; if (grant !== 5'b00001) begin miscompares++; $display("[TB] FAIL drop_first_grant: got %b expected 00001", grant); end
      Y  = 4'd9;
      PB = 5'b00010;
      tick();
      vectors++; if (drop !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_pulse: got %0b expected 1", drop); end
      vectors++; if (pending !== 5'b00010) begin miscompares++; $display("[TB] FAIL drop_pending: got %b expected 00010", pending); end
      vectors++; if (sum !== 6'd5) begin miscompares++; $display("[TB] FAIL drop_sum_slot0: got %0d expected 5", sum); end
      PB = '0;
      tick();
      vectors++; if (drop !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_pulse_end: got %0b expected 0", drop); end
      vectors++; if (grant !== 5'b00010) begin miscompares++; $display("[TB] FAIL drop_second_grant: got %b expected 00010", grant); end
      tick();
      vectors++; if (sum !== 6'd10) begin miscompares++; $display("[TB] FAIL drop_opnd_kept: got %0d expected 10", sum); end

      Y  = 4'd2;
      PB = 5'b00010;
      tick();
      PB = '0;
      tick();
      vectors++; if (grant !== 5'b00010) begin miscompares++; $display("[TB] FAIL coll_grant: got %b expected 00010", grant); end
      Y  = 4'd7;
      PB = 5'b00010;
      tick();
      vectors++; if (sum !== 6'd12) begin miscompares++; $display("[TB] FAIL coll_sum_first: got %0d expected 12", sum); end
      vectors++; if (pending !== 5'b00010) begin miscompares++; $display("[TB] FAIL coll_pending_kept: got %b expected 00010", pending); end
      vectors++; if (drop !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_no_drop: got %0b expected 0", drop); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_done: got %0b expected 1", done); end
      PB = '0;
      tick();
      vectors++; if (grant !== 5'b00010) begin miscompares++; $display("[TB] FAIL coll_regrant: got %b expected 00010", grant); end
      tick();
      vectors++; if (sum !== 6'd19) begin miscompares++; $display("[TB] FAIL coll_sum_second: got %0d expected 19", sum); end
      vectors++; if (pending !== 5'b0) begin miscompares++; $display("[TB] FAIL coll_pending_clear: got %b expected 00000", pending); end
   endtask

   task automatic test_reset_mid_add();
      Y  = 4'd4;
      PB = 5'b00001;
      tick();
      PB = '0;
      tick();
      vectors++; if (grant !== 5'b00001) begin miscompares++; $display("[TB] FAIL midadd_grant: got %b expected 00001", grant); end
      reset = 1'b1;
      tick();
      vectors++; if (sum !== 6'd0) begin miscompares++; $display("[TB] FAIL midadd_sum: got %0d expected 0", sum); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL midadd_carry: got %0b expected 0", carry); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL midadd_done: got %0b expected 0", done); end
      vectors++; if (pending !== 5'b0) begin miscompares++; $display("[TB] FAIL midadd_pending: got %b expected 00000", pending); end
      vectors++; if (grant !== 5'b0) begin miscompares++; $display("[TB] FAIL midadd_grant_clear: got %b expected 00000", grant); end
      reset = 1'b0;
      tick();
      tick();
      vectors++; if (sum !== 6'd0) begin miscompares++; $display("[TB] FAIL midadd_discarded: got %0d expected 0", sum); end
      vectors++; if (grant !== 5'b0) begin miscompares++; $display("[TB] FAIL midadd_idle: got %b expected 00000", grant); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      PB          = '0;
      Y           = '0;
      test_reset();
      test_single_add();
      test_overflow();
      test_round_robin();
      test_drop_collision();
      test_reset_mid_add();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
